// File: rtl/morse_decoder.sv
// Morse decoder: classifies up to five recorded pulse durations as dots/dashes, walks the
// Morse binary tree one symbol per cycle and emits one ASCII character per message.
module morse_decoder #(
    parameter int unsigned WID      = 32,
    parameter int unsigned DASH_MIN = 6,
    parameter int unsigned MAX_DUR  = 30
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m_end,
    input  logic [5*WID-1:0] durations,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [7:0]       ascii,
    output logic [2:0]       sym_len,
    output logic [4:0]       pattern,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {StIdle, StScan, StLookup, StDone} state_e;

    state_e             r_state, w_state_d;
    logic               r_mend_q;
    logic [5*WID-1:0]   r_dur, w_dur_d;
    logic [2:0]         r_slot, w_slot_d;
    logic [5:0]         r_idx, w_idx_d;
    logic               r_valid, w_valid_d;
    logic [7:0]         r_ascii, w_ascii_d;
    logic [2:0]         r_len, w_len_d;
    logic [4:0]         r_pat, w_pat_d;
    logic               r_err, w_err_d;

    logic               w_start;
    logic [WID-1:0]     w_cur;
    logic               w_dash;
    logic [7:0]         w_char;
    logic               w_hit;

    assign w_start = m_end & ~r_mend_q;
    // The working copy shifts right one slot per SCAN cycle, so the current slot is always low.
    assign w_cur   = r_dur[WID-1:0];
    assign w_dash  = (w_cur >= WID'(DASH_MIN));

    // Tree index: root = 1, dot -> 2*idx, dash -> 2*idx+1.
    always_comb begin
        w_hit  = 1'b1;
        w_char = 8'h00;
        case (r_idx)
            6'd2:  w_char = 8'h45; // E
            6'd3:  w_char = 8'h54; // T
            6'd4:  w_char = 8'h49; // I
            6'd5:  w_char = 8'h41; // A
            6'd6:  w_char = 8'h4E; // N
            6'd7:  w_char = 8'h4D; // M
            6'd8:  w_char = 8'h53; // S
            6'd9:  w_char = 8'h55; // U
            6'd10: w_char = 8'h52; // R
            6'd11: w_char = 8'h57; // W
            6'd12: w_char = 8'h44; // D
            6'd13: w_char = 8'h4B; // K
            6'd14: w_char = 8'h47; // G
            6'd15: w_char = 8'h4F; // O
            6'd16: w_char = 8'h48; // H
            6'd17: w_char = 8'h56; // V
            6'd18: w_char = 8'h46; // F
            6'd20: w_char = 8'h4C; // L
            6'd22: w_char = 8'h50; // P
            6'd23: w_char = 8'h4A; // J
            6'd24: w_char = 8'h42; // B
            6'd25: w_char = 8'h58; // X
            6'd26: w_char = 8'h43; // C
            6'd27: w_char = 8'h59; // Y
            6'd28: w_char = 8'h5A; // Z
            6'd29: w_char = 8'h51; // Q
            6'd32: w_char = 8'h35; // 5
            6'd33: w_char = 8'h34; // 4
            6'd35: w_char = 8'h33; // 3
            6'd39: w_char = 8'h32; // 2
            6'd47: w_char = 8'h31; // 1
            6'd48: w_char = 8'h36; // 6
            6'd56: w_char = 8'h37; // 7
            6'd60: w_char = 8'h38; // 8
            6'd62: w_char = 8'h39; // 9
            6'd63: w_char = 8'h30; // 0
            default: w_hit = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_dur_d   = r_dur;
        w_slot_d  = r_slot;
        w_idx_d   = r_idx;
        w_valid_d = r_valid;
        w_ascii_d = r_ascii;
        w_len_d   = r_len;
        w_pat_d   = r_pat;
        w_err_d   = r_err;
        unique case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_dur_d   = durations;
                    w_slot_d  = 3'd0;
                    w_idx_d   = 6'd1;
                    w_len_d   = 3'd0;
                    w_pat_d   = 5'd0;
                    w_err_d   = 1'b0;
                    w_state_d = StScan;
                end
            end
            StScan: begin
                if (w_cur == '0) begin
                    w_err_d   = r_err | (r_slot == 3'd0);
                    w_state_d = StLookup;
                end else if (w_cur > WID'(MAX_DUR)) begin
                    w_err_d   = 1'b1;
                    w_state_d = StLookup;
                end else begin
                    w_idx_d  = {r_idx[4:0], w_dash};
                    w_pat_d  = r_pat | (5'(w_dash) << r_slot);
                    w_len_d  = r_len + 3'd1;
                    w_dur_d  = r_dur >> WID;
                    w_slot_d = r_slot + 3'd1;
                    if (r_slot == 3'd4) begin
                        w_state_d = StLookup;
                    end
                end
            end
            StLookup: begin
                if (r_err || !w_hit) begin
                    w_ascii_d = 8'h3F;
                    w_err_d   = 1'b1;
                end else begin
                    w_ascii_d = w_char;
                end
                w_valid_d = 1'b1;
                w_state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_valid_d = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= StIdle;
            r_mend_q <= 1'b1;  // a level already high out of reset must not count as an edge
            r_dur    <= '0;
            r_slot   <= 3'd0;
            r_idx    <= 6'd1;
            r_valid  <= 1'b0;
            r_ascii  <= 8'h00;
            r_len    <= 3'd0;
            r_pat    <= 5'd0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_mend_q <= m_end;
            r_dur    <= w_dur_d;
            r_slot   <= w_slot_d;
            r_idx    <= w_idx_d;
            r_valid  <= w_valid_d;
            r_ascii  <= w_ascii_d;
            r_len    <= w_len_d;
            r_pat    <= w_pat_d;
            r_err    <= w_err_d;
        end
    end

    assign out_valid = r_valid;
    assign ascii     = r_ascii;
    assign sym_len   = r_len;
    assign pattern   = r_pat;
    assign err       = r_err;
    assign busy      = (r_state != StIdle);

endmodule

// File: tb/tb_morse_decoder.sv
// Directed, table-driven bench for morse_decoder with hand-written handshake/reset sequences.
module tb_morse_decoder;

    localparam int unsigned WID = 32;

    logic             clk;
    logic             reset;
    logic             m_end;
    logic [5*WID-1:0] durations;
    logic             out_ready;
    logic             out_valid;
    logic [7:0]       ascii;
    logic [2:0]       sym_len;
    logic [4:0]       pattern;
    logic             err;
    logic             busy;

    int checks = 0;
    int errors = 0;

    morse_decoder #(.WID(WID), .DASH_MIN(6), .MAX_DUR(30)) dut (
        .clk       (clk),
        .reset     (reset),
        .m_end     (m_end),
        .durations (durations),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .ascii     (ascii),
        .sym_len   (sym_len),
        .pattern   (pattern),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5*WID-1:0] d;
        logic [7:0]       asc;
        logic [2:0]       len;
        logic [4:0]       pat;
        logic             er;
        int               lat;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5*WID-1:0] mk(input int unsigned s0, input int unsigned s1,
                                            input int unsigned s2, input int unsigned s3,
                                            input int unsigned s4);
        return {s4, s3, s2, s1, s0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Raise m_end freshly; returns the edge offset from E0 at which out_valid is seen, -1 on timeout.
    task automatic start_decode(input logic [5*WID-1:0] d, output int lat);
        @(negedge clk);
        durations = d;
        m_end     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        m_end = 1'b1;
        lat   = -1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic accept(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " busy_drop"}, 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        m_end     = 1'b0;
    endtask

    int lat;
    logic [7:0] held_ascii;

    initial begin
        reset     = 1'b1;
        m_end     = 1'b0;
        out_ready = 1'b0;
        durations = '0;

        vecs[0]  = '{d: mk(3, 9, 0, 0, 0),     asc: 8'h41, len: 3'd2, pat: 5'b00010, er: 1'b0, lat: 4};
        vecs[1]  = '{d: mk(2, 2, 2, 2, 2),     asc: 8'h35, len: 3'd5, pat: 5'b00000, er: 1'b0, lat: 6};
        vecs[2]  = '{d: mk(10, 10, 10, 10, 10), asc: 8'h30, len: 3'd5, pat: 5'b11111, er: 1'b0, lat: 6};
        vecs[3]  = '{d: mk(8, 8, 2, 8, 0),     asc: 8'h51, len: 3'd4, pat: 5'b01011, er: 1'b0, lat: 6};
        vecs[4]  = '{d: mk(2, 2, 8, 8, 0),     asc: 8'h3F, len: 3'd4, pat: 5'b01100, er: 1'b1, lat: 6};
        vecs[5]  = '{d: mk(0, 0, 0, 0, 0),     asc: 8'h3F, len: 3'd0, pat: 5'b00000, er: 1'b1, lat: 2};
        vecs[6]  = '{d: mk(3, 31, 0, 0, 0),    asc: 8'h3F, len: 3'd1, pat: 5'b00000, er: 1'b1, lat: 3};
        vecs[7]  = '{d: mk(1, 0, 0, 0, 0),     asc: 8'h45, len: 3'd1, pat: 5'b00000, er: 1'b0, lat: 3};
        vecs[8]  = '{d: mk(6, 0, 0, 0, 0),     asc: 8'h54, len: 3'd1, pat: 5'b00001, er: 1'b0, lat: 3};
        vecs[9]  = '{d: mk(30, 30, 0, 0, 0),   asc: 8'h4D, len: 3'd2, pat: 5'b00011, er: 1'b0, lat: 4};
        vecs[10] = '{d: mk(5, 0, 0, 0, 0),     asc: 8'h45, len: 3'd1, pat: 5'b00000, er: 1'b0, lat: 3};
        vecs[11] = '{d: mk(3, 0, 9, 9, 9),     asc: 8'h45, len: 3'd1, pat: 5'b00000, er: 1'b0, lat: 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst ascii", 32'(ascii), 32'd0);
        chk("rst sym_len", 32'(sym_len), 32'd0);
        chk("rst pattern", 32'(pattern), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            start_decode(vecs[i].d, lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d ascii", i), 32'(ascii), 32'(vecs[i].asc));
            chk($sformatf("v%0d sym_len", i), 32'(sym_len), 32'(vecs[i].len));
            chk($sformatf("v%0d pattern", i), 32'(pattern), 32'(vecs[i].pat));
            chk($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].er));
            chk($sformatf("v%0d busy", i), 32'(busy), 32'd1);
            accept($sformatf("v%0d", i));
            chk($sformatf("v%0d ascii_kept", i), 32'(ascii), 32'(vecs[i].asc));
        end

        // Backpressure: hold 10 cycles, with a fresh m_end pulse while waiting.
        start_decode(mk(8, 8, 2, 8, 0), lat);
        chk("hold latency", 32'(lat), 32'd6);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) m_end = 1'b0;
            if (c == 5) m_end = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d valid", c), 32'(out_valid), 32'd1);
            chk($sformatf("hold%0d ascii", c), 32'(ascii), 32'h51);
            chk($sformatf("hold%0d pattern", c), 32'(pattern), 32'h0B);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold release valid", 32'(out_valid), 32'd0);
        chk("hold release busy", 32'(busy), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        // m_end is still high: the pulse during DONE must not queue a new decode.
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("no_requeue%0d busy", c), 32'(busy), 32'd0);
        end

        // Reset during SCAN with m_end held high across it.
        @(negedge clk);
        m_end     = 1'b0;
        durations = mk(10, 10, 10, 10, 10);
        @(negedge clk);
        m_end = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_rst busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("scan_rst out_valid", 32'(out_valid), 32'd0);
        chk("scan_rst ascii", 32'(ascii), 32'd0);
        chk("scan_rst sym_len", 32'(sym_len), 32'd0);
        chk("scan_rst pattern", 32'(pattern), 32'd0);
        chk("scan_rst err", 32'(err), 32'd0);
        chk("scan_rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held_mend%0d busy", c), 32'(busy), 32'd0);
        end
        start_decode(mk(10, 10, 10, 10, 10), lat);
        chk("post_rst latency", 32'(lat), 32'd6);
        chk("post_rst ascii", 32'(ascii), 32'h30);

        // Reset while DONE drops the pending character.
        held_ascii = ascii;
        chk("done_rst pre valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("done_rst valid", 32'(out_valid), 32'd0);
        chk("done_rst ascii", 32'(ascii), 32'd0);
        chk("done_rst prev_ascii", 32'(held_ascii), 32'h30);
        @(negedge clk);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
